// File: rtl/pipelined_mac_array.sv
// pipelined_mac_array: LANES-wide two-stage multiply-accumulate with valid/ready in/out streams.
// Build option MAC_SATURATE_EN: overflowing lane accumulators clamp instead of wrapping.
module pipelined_mac_array #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]      in_a,
  input  logic [LANES*DATA_WIDTH-1:0]      in_b,
  input  logic                             in_signed,
  input  logic                             in_first,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*ACC_WIDTH-1:0]       out_acc,
  output logic [LANES-1:0]                 out_ovf,
  output logic [CNT_WIDTH-1:0]             out_count,
  output logic                             busy,
  output logic                             proto_err
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
`ifdef MAC_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  typedef enum logic [0:0] {IDLE = 1'b0, OPEN = 1'b1} state_t;

  // Low PW bits of the product of extended operands are exact for both modes.
  function automatic logic [PW-1:0] mul_ext(input logic [DATA_WIDTH-1:0] a,
                                            input logic [DATA_WIDTH-1:0] b,
                                            input logic sgn);
    logic [PW-1:0] ea;
    logic [PW-1:0] eb;
    if (sgn) begin
      ea = PW'($signed(a));
      eb = PW'($signed(b));
    end else begin
      ea = PW'(a);
      eb = PW'(b);
    end
    return ea * eb;
  endfunction

  // Returns {ovf, acc} after one beat; a vector start loads and clears ovf.
  function automatic logic [ACC_WIDTH:0] lane_step(input logic [ACC_WIDTH-1:0] acc,
                                                   input logic [PW-1:0] p,
                                                   input logic sgn,
                                                   input logic start,
                                                   input logic ovf_in);
    logic [ACC_WIDTH-1:0] pe;
    logic [ACC_WIDTH-1:0] sum;
    logic                 add_ovf;
    logic [ACC_WIDTH:0]   res;
    if (sgn) begin
      pe = ACC_WIDTH'($signed(p));
    end else begin
      pe = ACC_WIDTH'(p);
    end
    sum     = acc + pe;
    add_ovf = (acc[ACC_WIDTH-1] == pe[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    if (start) begin
      res = {1'b0, pe};
    end else if (add_ovf) begin
`ifdef MAC_SATURATE_EN
      res = {1'b1, (acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX)};
`else
      res = {1'b1, sum};
`endif
    end else begin
      res = {ovf_in, sum};
    end
    return res;
  endfunction

  logic                       stall_s;
  logic                       accept_s;
  logic                       acc_en_s;
  logic                       start_s;
  logic                       p_valid_r;
  logic                       p_first_r;
  logic                       p_last_r;
  logic                       p_signed_r;
  logic [LANES*PW-1:0]        prod_s;
  logic [LANES*PW-1:0]        prod_r;
  logic [LANES*ACC_WIDTH-1:0] acc_r;
  logic [LANES*ACC_WIDTH-1:0] acc_nxt_s;
  logic [LANES-1:0]           ovf_r;
  logic [LANES-1:0]           ovf_nxt_s;
  logic [CNT_WIDTH-1:0]       cnt_r;
  logic [CNT_WIDTH-1:0]       cnt_nxt_s;
  state_t                     state_r;
  state_t                     state_nxt_s;

  assign stall_s  = out_valid & ~out_ready;
  assign in_ready = ~stall_s;
  assign accept_s = in_valid & in_ready;
  assign acc_en_s = p_valid_r & ~stall_s;
  // An explicit first, or any beat arriving with no vector open, starts a vector.
  assign start_s  = p_first_r | (state_r == IDLE);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [ACC_WIDTH:0] step_s;
    assign prod_s[g*PW +: PW] = mul_ext(in_a[g*DATA_WIDTH +: DATA_WIDTH],
                                        in_b[g*DATA_WIDTH +: DATA_WIDTH], in_signed);
    assign step_s = lane_step(acc_r[g*ACC_WIDTH +: ACC_WIDTH], prod_r[g*PW +: PW],
                              p_signed_r, start_s, ovf_r[g]);
    assign acc_nxt_s[g*ACC_WIDTH +: ACC_WIDTH] = step_s[ACC_WIDTH-1:0];
    assign ovf_nxt_s[g] = step_s[ACC_WIDTH];
  end

  // Beat counter next value, saturating at all-ones.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (start_s) begin
      cnt_nxt_s = CNT_ONE;
    end else if (&cnt_r) begin
      cnt_nxt_s = cnt_r;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Stage 1: register products and beat tags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_valid_r  <= 1'b0;
      p_first_r  <= 1'b0;
      p_last_r   <= 1'b0;
      p_signed_r <= 1'b0;
      prod_r     <= '0;
    end else if (!stall_s) begin
      p_valid_r <= accept_s;
      if (accept_s) begin
        p_first_r  <= in_first;
        p_last_r   <= in_last;
        p_signed_r <= in_signed;
        prod_r     <= prod_s;
      end
    end
  end

  // Stage 2: accumulators, sticky ovf, beat counter, protocol error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r     <= '0;
      ovf_r     <= '0;
      cnt_r     <= '0;
      proto_err <= 1'b0;
    end else if (acc_en_s) begin
      acc_r <= acc_nxt_s;
      ovf_r <= ovf_nxt_s;
      cnt_r <= cnt_nxt_s;
      if (p_first_r && (state_r == OPEN)) begin
        proto_err <= 1'b1;
      end
    end
  end

  // Result register: a new result may replace one being consumed in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= '0;
      out_count <= '0;
    end else if (acc_en_s && p_last_r) begin
      out_valid <= 1'b1;
      out_acc   <= acc_nxt_s;
      out_ovf   <= ovf_nxt_s;
      out_count <= cnt_nxt_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Vector state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Vector state transitions on accumulated beats.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (acc_en_s && !p_last_r) begin
          state_nxt_s = OPEN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OPEN: begin
        if (acc_en_s && p_last_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OPEN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Busy decode from the vector state.
  always_comb begin
    busy = 1'b0;
    case (state_r)
      OPEN:    busy = 1'b1;
      IDLE:    busy = 1'b0;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_pipelined_mac_array.sv
// Bench for pipelined_mac_array: directed cases plus random vectors against a queue-based model.
module tb_pipelined_mac_array;
  localparam int LN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         in_valid, in_ready, in_signed, in_first, in_last;
  logic [31:0]  in_a, in_b;
  logic         out_valid, out_ready, busy, proto_err;
  logic [127:0] out_acc;
  logic [3:0]   out_ovf;
  logic [15:0]  out_count;

  logic         d_in_valid, d_in_ready, d_in_signed, d_in_first, d_in_last;
  logic [31:0]  d_in_a, d_in_b;
  logic         d_out_valid, d_out_ready, d_busy, d_proto_err;
  logic [63:0]  d_out_acc;
  logic [3:0]   d_out_ovf;
  logic [1:0]   d_out_count;

  pipelined_mac_array u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .in_first(in_first), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf), .out_count(out_count),
    .busy(busy), .proto_err(proto_err));

  pipelined_mac_array #(.ACC_WIDTH(16), .CNT_WIDTH(2)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_a(d_in_a),
    .in_b(d_in_b), .in_signed(d_in_signed), .in_first(d_in_first), .in_last(d_in_last),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_acc(d_out_acc), .out_ovf(d_out_ovf),
    .out_count(d_out_count), .busy(d_busy), .proto_err(d_proto_err));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Behavioural model: exact integer arithmetic per vector, results queued in order.
  typedef struct {
    logic [127:0] acc;
    logic [3:0]   ovf;
    logic [15:0]  cnt;
    logic         perr;
  } res_t;
  res_t   q[$];
  longint macc[LN];
  logic [3:0] movf;
  int     mcnt;
  bit     mopen, mperr;
  localparam longint AMAX = 64'sd2147483647;
  localparam longint AMIN = -64'sd2147483648;
  localparam longint AMOD = 64'sd4294967296;

  task automatic model_reset();
    q.delete();
    mopen = 1'b0;
    mperr = 1'b0;
    mcnt  = 0;
    movf  = 4'b0000;
    for (int i = 0; i < LN; i++) macc[i] = 0;
  endtask

  task automatic model_beat(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                            input logic first, input logic last);
    longint p, s;
    byte    sa, sb;
    bit     start;
    res_t   r;
    if (first && mopen) mperr = 1'b1;
    start = first || !mopen;
    for (int i = 0; i < LN; i++) begin
      sa = a[i*8 +: 8];
      sb = b[i*8 +: 8];
      if (sgn) p = longint'(sa) * longint'(sb);
      else     p = longint'(a[i*8 +: 8]) * longint'(b[i*8 +: 8]);
      if (start) begin
        macc[i] = p;
        movf[i] = 1'b0;
      end else begin
        s = macc[i] + p;
        if (s > AMAX || s < AMIN) begin
          movf[i] = 1'b1;
`ifdef MAC_SATURATE_EN
          s = (s > AMAX) ? AMAX : AMIN;
`else
          s = (s > AMAX) ? s - AMOD : s + AMOD;
`endif
        end
        macc[i] = s;
      end
    end
    mcnt  = start ? 1 : ((mcnt < 65535) ? mcnt + 1 : 65535);
    mopen = !last;
    if (last) begin
      for (int i = 0; i < LN; i++) r.acc[i*32 +: 32] = macc[i][31:0];
      r.ovf  = movf;
      r.cnt  = mcnt[15:0];
      r.perr = mperr;
      q.push_back(r);
    end
  endtask

  // Every cycle: handshake rule, and any presented result against the model queue.
  always @(negedge clk) begin
    if (!reset) begin
      check("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (out_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result got acc=%0h exp=none", out_acc);
        end else begin
          check("res_acc", out_acc, q[0].acc);
          check("res_ovf", out_ovf, q[0].ovf);
          check("res_count", out_count, q[0].cnt);
          check("res_proto_err", proto_err, q[0].perr);
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  bit rand_ready = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                      input logic first, input logic last);
    bit ok = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_signed = sgn; in_first = first; in_last = last;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        model_beat(a, b, sgn, first, last);
      end
      @(posedge clk);
      #1;
    end
    check("beat_accepted", ok, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic d_beat(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic first, input logic last);
    d_in_valid = 1'b1; d_in_a = a; d_in_b = b; d_in_signed = sgn; d_in_first = first; d_in_last = last;
    @(negedge clk);
    check("d16_in_ready", d_in_ready, 1'b1);
    @(posedge clk);
    #1;
    d_in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_valid"}, out_valid, 1'b1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_queue_empty"}, q.size(), 0);
  endtask

  int  vlen;
  bit  nofirst, nolast;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0; in_signed = 1'b0; in_first = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    d_in_valid = 1'b0; d_in_a = 32'h0; d_in_b = 32'h0; d_in_signed = 1'b0;
    d_in_first = 1'b0; d_in_last = 1'b0; d_out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_acc", out_acc, 128'h0);
    check("rst_out_ovf", out_ovf, 4'h0);
    check("rst_out_count", out_count, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_proto_err", proto_err, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    reset = 1'b0;

    // Single-beat signed vector: lane0 -3*7, lane3 127*127.
    beat({8'h7F, 8'h00, 8'h00, 8'hFD}, {8'h7F, 8'h00, 8'h00, 8'h07}, 1'b1, 1'b1, 1'b1);
    check("A_not_yet_valid", out_valid, 1'b0);
    check("A_model_pin_lane0", q[0].acc[31:0], 32'hFFFF_FFEB);
    @(posedge clk);
    #1;
    check("A_valid", out_valid, 1'b1);
    check("A_lane0", out_acc[31:0], 32'hFFFF_FFEB);
    check("A_lane3", out_acc[127:96], 32'd16129);
    check("A_count", out_count, 16'd1);
    check("A_ovf", out_ovf, 4'h0);
    @(posedge clk);
    #1;

    // Four-beat unsigned vector with busy window.
    beat(32'h0000_FF80, 32'h0000_FF80, 1'b0, 1'b1, 1'b0);
    check("B_busy_b1", busy, 1'b0);
    beat(32'h0000_FF80, 32'h0000_FF80, 1'b0, 1'b0, 1'b0);
    check("B_busy_b2", busy, 1'b1);
    beat(32'h0000_FF80, 32'h0000_FF80, 1'b0, 1'b0, 1'b0);
    check("B_busy_b3", busy, 1'b1);
    beat(32'h0000_FF80, 32'h0000_FF80, 1'b0, 1'b0, 1'b1);
    check("B_busy_b4", busy, 1'b1);
    @(posedge clk);
    #1;
    check("B_busy_end", busy, 1'b0);
    check("B_valid", out_valid, 1'b1);
    check("B_lane0", out_acc[31:0], 32'd65536);
    check("B_lane1", out_acc[63:32], 32'd260100);
    check("B_count", out_count, 16'd4);
    @(posedge clk);
    #1;

    // Backpressure: result 1 held while vector 2 streams in.
    out_ready = 1'b0;
    beat($urandom, $urandom, 1'b1, 1'b1, 1'b1);
    fork
      begin
        beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        check("C_in_ready_low", in_ready, 1'b0);
        check("C_held_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("C");

    // First mid-vector: error flagged, only the new vector counts.
    beat(32'h05, 32'h05, 1'b1, 1'b1, 1'b0);
    beat(32'h05, 32'h05, 1'b1, 1'b0, 1'b0);
    beat(32'h05, 32'h05, 1'b1, 1'b1, 1'b0);
    beat(32'h05, 32'h05, 1'b1, 1'b0, 1'b1);
    wait_valid("P");
    check("P_proto_err", proto_err, 1'b1);
    check("P_lane0", out_acc[31:0], 32'd50);
    check("P_count", out_count, 16'd2);
    @(posedge clk);
    #1;

    // Reset mid-vector.
    beat(32'h09, 32'h09, 1'b1, 1'b1, 1'b0);
    beat(32'h09, 32'h09, 1'b1, 1'b0, 1'b0);
    check("R_busy_before", busy, 1'b1);
    reset = 1'b1;
    model_reset();
    #1;
    check("R_out_valid", out_valid, 1'b0);
    check("R_out_acc", out_acc, 128'h0);
    check("R_out_ovf", out_ovf, 4'h0);
    check("R_out_count", out_count, 16'h0);
    check("R_busy", busy, 1'b0);
    check("R_proto_err", proto_err, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    beat(32'h02, 32'h03, 1'b0, 1'b1, 1'b1);
    wait_valid("R2");
    check("R2_lane0", out_acc[31:0], 32'd6);
    check("R2_count", out_count, 16'd1);
    @(posedge clk);
    #1;

    // Random vectors with random backpressure, gaps, implicit starts and missing lasts.
    rand_ready = 1'b1;
    for (int v = 0; v < 300; v++) begin
      vlen    = $urandom_range(1, 6);
      nofirst = ($urandom_range(0, 9) == 0);
      nolast  = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < vlen; k++) begin
        beat($urandom, $urandom, 1'($urandom_range(0, 1)), (k == 0) && !nofirst,
             (k == vlen - 1) && !nolast);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    wait_drain("RND");
    check("RND_out_valid_idle", out_valid, 1'b0);

    // 16-bit accumulator, 2-bit counter: overflow in both directions, then count saturation.
    d_beat(32'h0000_807F, 32'h0000_7F7F, 1'b1, 1'b1, 1'b0);
    d_beat(32'h0000_807F, 32'h0000_7F7F, 1'b1, 1'b0, 1'b0);
    d_beat(32'h0000_807F, 32'h0000_7F7F, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("D_valid", d_out_valid, 1'b1);
    check("D_ovf", d_out_ovf, 4'b0011);
`ifdef MAC_SATURATE_EN
    check("D_lane0_sat", d_out_acc[15:0], 16'h7FFF);
    check("D_lane1_sat", d_out_acc[31:16], 16'h8000);
`else
    check("D_lane0_wrap", d_out_acc[15:0], 16'hBD03);
    check("D_lane1_wrap", d_out_acc[31:16], 16'h4180);
`endif
    check("D_count", d_out_count, 2'd3);
    for (int k = 0; k < 5; k++) d_beat(32'h01, 32'h01, 1'b0, k == 0, k == 4);
    @(posedge clk);
    #1;
    check("D2_valid", d_out_valid, 1'b1);
    check("D2_lane0", d_out_acc[15:0], 16'd5);
    check("D2_ovf", d_out_ovf, 4'b0000);
    check("D2_count_sat", d_out_count, 2'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
